// File: rtl/par_pkg.sv
// Shared definitions for the 8-bit parallel frame link (receive side and transmit side).
package par_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned ERR_W  = 4;

    localparam int unsigned ERR_SHORT = 0;
    localparam int unsigned ERR_LONG  = 1;
    localparam int unsigned ERR_CSUM  = 2;
    localparam int unsigned ERR_OVF   = 3;

    typedef enum logic [2:0] {
        IDLE,
        PAY,
        CSUM,
        TAIL,
        DROP
    } state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/par_rx_fifo.sv
// First-word fall-through payload FIFO; a write while full is accepted when a read frees the slot.
module par_rx_fifo
    import par_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  fifo_entry_t wr_data,
    output logic        full,
    input  logic        rd_en,
    output fifo_entry_t rd_data,
    output logic        empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    fifo_entry_t mem [DEPTH];
    logic        wr_go;
    logic        rd_go;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_go   = rd_en && !empty;
    assign wr_go   = wr_en && (!full || rd_go);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_go) wr_ptr <= wr_ptr + 1'b1;
            if (rd_go) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_go) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/par_rx.sv
// Parallel link receiver: parses length-prefixed frames, checks the checksum,
// streams payload through a FIFO and reports per-frame status and counters.
module par_rx
    import par_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              run_in,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              frame_done,
    output logic [ERR_W-1:0]  frame_err,
    output logic [CNT_W-1:0]  good_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    logic [DATA_W-1:0] data_q;
    logic              run_q;
    logic              run_d;
    state_t            state;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  cnt;
    logic [DATA_W-1:0] sum;
    logic [ERR_W-1:0]  err_acc;

    logic              fifo_full;
    logic              fifo_empty;
    fifo_entry_t       rd_entry;
    fifo_entry_t       wr_entry_c;
    logic              pay_byte_c;
    logic              rd_fire_c;
    logic              wr_ok_c;
    logic              fin_c;
    logic [ERR_W-1:0]  fin_err_c;

    // run_q/run_d come out of reset high so a frame in flight never looks like a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            run_q  <= 1'b1;
            run_d  <= 1'b1;
        end else begin
            data_q <= data_in;
            run_q  <= run_in;
            run_d  <= run_q;
        end
    end

    assign pay_byte_c = (state == PAY) && run_q;
    assign rd_fire_c  = m_ready && !fifo_empty;
    assign wr_ok_c    = !fifo_full || rd_fire_c;
    assign wr_entry_c = '{last: (cnt == len - 1'b1), data: data_q};

    // Frame end detection and the final status word for this frame.
    always_comb begin
        fin_c     = 1'b0;
        fin_err_c = err_acc;
        case (state)
            PAY, CSUM: begin
                if (!run_q) begin
                    fin_c                = 1'b1;
                    fin_err_c[ERR_SHORT] = 1'b1;
                end
            end
            TAIL:    if (!run_q) fin_c = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DROP;
            len        <= '0;
            cnt        <= '0;
            sum        <= '0;
            err_acc    <= '0;
            frame_done <= 1'b0;
            frame_err  <= '0;
            good_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            frame_done <= 1'b0;
            if (fin_c) begin
                frame_done <= 1'b1;
                frame_err  <= fin_err_c;
                if (fin_err_c == '0) begin
                    if (good_cnt != '1) good_cnt <= good_cnt + 1'b1;
                end else if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (run_q && !run_d) begin
                        len     <= data_q;
                        cnt     <= '0;
                        sum     <= '0;
                        err_acc <= '0;
                        state   <= (data_q == '0) ? CSUM : PAY;
                    end
                end
                PAY: begin
                    if (run_q) begin
                        // Dropped bytes still count toward the checksum.
                        sum <= sum + data_q;
                        cnt <= cnt + 1'b1;
                        if (!wr_ok_c) err_acc[ERR_OVF] <= 1'b1;
                        if (cnt == len - 1'b1) state <= CSUM;
                    end else begin
                        state <= IDLE;
                    end
                end
                CSUM: begin
                    if (run_q) begin
                        if (DATA_W'(sum + data_q) != '0) err_acc[ERR_CSUM] <= 1'b1;
                        state <= TAIL;
                    end else begin
                        state <= IDLE;
                    end
                end
                TAIL: begin
                    if (run_q) err_acc[ERR_LONG] <= 1'b1;
                    else       state <= IDLE;
                end
                DROP:    if (!run_q) state <= IDLE;
                default: state <= DROP;
            endcase
        end
    end

    par_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pay_byte_c),
        .wr_data (wr_entry_c),
        .full    (fifo_full),
        .rd_en   (m_ready),
        .rd_data (rd_entry),
        .empty   (fifo_empty)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = fifo_empty ? '0 : rd_entry.data;
    assign m_last  = !fifo_empty && rd_entry.last;

endmodule

// File: doc/par_rx.md
# par_rx

Receive end of the 8-bit parallel frame link driven by the memory controller's `data_out`/`run` header port. It samples an 8-bit data bus and a `run` frame-valid level, parses length-prefixed frames, and verifies a checksum. Payload bytes go into a small FIFO with a valid/ready output stream, and per-frame status and counters are reported. Typical use: loopback from header P4/P5 to another header on the same board, clocked by the same `clk`.

## Interface
Parameters:
- `DEPTH`, 16: payload FIFO depth in entries; power of two, 4..256.
- `CNT_W`, 16: width of the good-frame and error-frame counters.

Ports:
- `clk` in 1: system clock, the same `clk` produced by the memory controller.
- `rst` in 1: synchronous, active-high reset.
- `data_in` in 8: parallel data bus from the header.
- `run_in` in 1: frame-valid level; high for every cycle that carries a frame byte.
- `m_data` out 8: payload byte at the FIFO head.
- `m_last` out 1: head byte is the final payload byte of a frame that completed without a short error.
- `m_valid` out 1: FIFO not empty.
- `m_ready` in 1: consumer accepts the head byte when `m_valid & m_ready`.
- `frame_done` out 1: one-cycle pulse when a frame ends.
- `frame_err` out 4: status bits `{ovf, csum, long, short}`; valid while `frame_done` is high, and held until the next `frame_done`.
- `good_cnt` out CNT_W: number of frames ending with `frame_err==0`; saturates.
- `err_cnt` out CNT_W: number of frames ending with `frame_err!=0`; saturates.

## Operation
- **Input stage.** `data_in` and `run_in` are registered once into `data_q` and `run_q`. `run_d` is the previous `run_q`.
- **Frame format.** The frame is one byte per cycle while run is high:
  - byte 0: length N, where N is 0..255.
  - bytes 1..N: payload.
  - byte N+1: checksum C, such that (sum of payload + C) mod 256 == 0.
- **FSM states:**
  - IDLE: on `run_q & ~run_d`, latch N, clear the error bits and the 8-bit running sum, then go to PAY. If N==0, go to CSUM instead.
  - PAY: for each cycle with `run_q` high, add `data_q` to the sum and write {`data_q`, last=(count==N)} to the FIFO. After the Nth byte, go to CSUM. If `run_q` is low, set short, emit done, and go to IDLE.
  - CSUM: if `run_q` is high, set csum when `(sum + data_q) & 8'hFF != 0`, then go to TAIL. If `run_q` is low, set short, emit done, and go to IDLE.
  - TAIL: if `run_q` is high, set long and stay in TAIL (extra bytes are discarded). If `run_q` is low, emit done and go to IDLE.
  - DROP: entered only from reset. Wait until `run_q` is low, then go to IDLE. Nothing is written or reported.
- **FIFO full.** If the FIFO is full when a payload byte arrives, the byte is dropped and ovf is set. The sum still includes the dropped byte.
- **`m_last` on short frames.** The last entry of a short frame carries last=0. The consumer uses `frame_done` and `frame_err` to delimit such frames.
- **Frame end.** On done, `good_cnt` or `err_cnt` increments by 1. Both counters saturate at all-ones.

## Timing
- **Reset values.**
  - All outputs are 0 and the FIFO is empty.
  - FSM = DROP, and `run_d` is forced to 1, so a frame already in flight when reset releases is ignored.
  - Reset mid-frame discards the FIFO contents and produces no `frame_done`.
- **Payload latency.** A payload byte on the pins in cycle c is visible as `m_data`/`m_valid` in cycle c+2 when the FIFO is empty (first-word fall-through).
- **Done latency.** `frame_done` is asserted in cycle r+2, where r is the first pin cycle with `run_in` low after the frame.
- **Back-to-back frames.** The link needs a minimum of one low cycle between frames. A gap of exactly one cycle must work.
- **Simultaneous read and write at full.** A FIFO write and read in the same cycle while full both succeed, with no ovf. The read frees the slot, and occupancy is unchanged.
- **Read while empty.** `m_ready` while empty has no effect.
- **Unchecked ready.** `m_valid` does not depend on `m_ready` combinationally.
- **Pointer wrap.** FIFO pointers are log2(DEPTH)+1 bits. Full is declared when the MSBs differ and the other bits are equal.

## Structure
- Shared package `par_pkg`:
  - FSM state enum {IDLE, PAY, CSUM, TAIL, DROP}.
  - Error bit index constants ERR_SHORT=0, ERR_LONG=1, ERR_CSUM=2, ERR_OVF=3.
  - Frame field widths, for reuse by the memory-controller transmit side.
- Sub-module `par_rx_fifo`: synchronous first-word fall-through FIFO, 9 bits wide (data plus last), DEPTH entries, with wr_en/full and rd_en/empty.

## Test plan
- **Good frame.** N=3, payload 11 22 33, C=0x9A, run low after. Expected:
  - `m_data` 11/22/33 with `m_last` on 33.
  - `frame_done` with `frame_err`=0, and `good_cnt`=1.
- **Zero length.** N=0, C=0x00. Expected: no FIFO writes, `frame_done` with err=0.
- **Short and long.**
  - N=4 with run dropping after 2 payload bytes: err=0001, 2 bytes in the FIFO, none with last set.
  - A separate frame with 2 extra bytes after C: err=0010.
- **Checksum error.** Payload 01 02 with C=0x00. Expected: err=0100, `err_cnt` increments.
- **Overflow.** DEPTH=16, N=20, `m_ready` held 0. Expected: 16 entries stored and err=1000. Repeat with `m_ready`=1: no ovf.
- **Reset mid-frame.** Assert `rst` during PAY and release while run is still high. Expected: the rest of that frame is ignored with no `frame_done`, and the next frame is received cleanly.
